// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive controller.
// Detects start bits on the oversampling tick and takes a 2-of-3 majority
// around each bit centre. Data is shifted in LSB first, and the parity/stop
// checker is driven with strobes. One DATA_VALID or FRAME_ERR pulse is
// emitted per frame.
// Optional build macro: UART_RX_SYNC_EN adds a 2-flop synchronizer on RX_IN.
// Handshake: none; RX_tick is a qualifier pulse, and DATA_VALID/FRAME_ERR are
// single-cycle pulses with no back-pressure. P_DATA holds until the next good
// frame.
`timescale 1ns/1ps
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  RX_tick,
    input  logic                  PAR_EN,
    input  logic                  PARITY_ERROR,
    input  logic                  STOP_ERROR,
    output logic                  SER_DATA,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic                  ASS_EN,
    output logic                  STOP_EN,
    output logic                  TICK_EN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  FRAME_ERR,
    output logic                  BUSY,
    output logic [2:0]            STATE_DBG
);

    localparam int H  = OVERSAMPLE / 2;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [TW-1:0] T_HM1  = TW'(H - 1);
    localparam logic [TW-1:0] T_H    = TW'(H);
    localparam logic [TW-1:0] T_HP1  = TW'(H + 1);
    localparam logic [TW-1:0] T_HP2  = TW'(H + 2);
    localparam logic [TW-1:0] T_HP3  = TW'(H + 3);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            smp_q, smp_d;
    logic                  ser_data_q, ser_data_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_en_q, par_en_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rx_s;
    logic                  maj;
    logic                  last_tick;
    logic                  err;

`ifdef UART_RX_SYNC_EN
    logic sync1_q, sync2_q;
    // Two-flop synchronizer for the asynchronous serial line, idle high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
        end
    end
    assign rx_s = sync2_q;
`else
    assign rx_s = RX_IN;
`endif

    // Majority of the H-1 and H captures plus the live line at the H+1 tick.
    assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign last_tick = (tick_cnt_q == T_LAST);
    // Parity flag is stale when the frame carries no parity bit.
    assign err       = STOP_ERROR | (par_en_q & PARITY_ERROR);

    // Next-state, counters, sampling, shift register and result pulses.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        smp_d        = smp_q;
        ser_data_d   = ser_data_q;
        data_d       = data_q;
        p_data_d     = p_data_q;
        par_en_d     = par_en_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (RX_tick) begin
            if (state_q == S_IDLE) begin
                if (!rx_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_en_d   = PAR_EN;
                end
            end else begin
                tick_cnt_d = last_tick ? '0 : tick_cnt_q + TW'(1);
                if (tick_cnt_q == T_HM1) smp_d[0] = rx_s;
                if (tick_cnt_q == T_H)   smp_d[1] = rx_s;
                if (tick_cnt_q == T_HP1) ser_data_d = maj;
                case (state_q)
                    S_START: begin
                        if (tick_cnt_q == T_HP1 && maj) begin
                            state_d    = S_IDLE;
                            tick_cnt_d = '0;
                        end else if (last_tick) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt_q == T_HP1) data_d = {maj, data_q[DATA_WIDTH-1:1]};
                        if (last_tick) begin
                            if (bit_cnt_q == B_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
                            else                     bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (last_tick) state_d = S_STOP;
                    end
                    S_STOP: begin
                        // Leave at H+3 rather than the bit end so the next start edge is caught early.
                        if (tick_cnt_q == T_HP3) begin
                            if (err) begin
                                frame_err_d = 1'b1;
                            end else begin
                                data_valid_d = 1'b1;
                                p_data_d     = data_q;
                            end
                            state_d    = S_IDLE;
                            tick_cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d    = S_IDLE;
                        tick_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    // State and datapath registers, asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            smp_q        <= 2'b11;
            ser_data_q   <= 1'b1;
            data_q       <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            smp_q        <= smp_d;
            ser_data_q   <= ser_data_d;
            data_q       <= data_d;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign SER_DATA   = ser_data_q;
    assign DATA       = data_q;
    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign FRAME_ERR  = frame_err_q;
    assign ASS_EN     = (state_q == S_PARITY);
    assign STOP_EN    = (state_q == S_STOP);
    assign BUSY       = (state_q != S_IDLE);
    assign TICK_EN    = (state_q == S_PARITY || state_q == S_STOP) && (tick_cnt_q == T_HP2);
    assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm. It serialises frames bit by bit and includes a
// model of the external parity/stop checker. Each frame's expected outcome
// ({err, data}) comes from the frame's own bits and is queued; pulses from
// the DUT are checked against that queue.
`timescale 1ns/1ps
module tb_uart_rx_fsm;
    localparam int DW = 8;
    localparam int OS = 16;
    localparam int H  = OS / 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          RX_tick = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PARITY_ERROR;
    logic          STOP_ERROR;
    logic          SER_DATA;
    logic [DW-1:0] DATA;
    logic          ASS_EN;
    logic          STOP_EN;
    logic          TICK_EN;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          FRAME_ERR;
    logic          BUSY;
    logic [2:0]    STATE_DBG;

    uart_rx_fsm #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .RX_tick(RX_tick), .PAR_EN(PAR_EN),
        .PARITY_ERROR(PARITY_ERROR), .STOP_ERROR(STOP_ERROR), .SER_DATA(SER_DATA),
        .DATA(DATA), .ASS_EN(ASS_EN), .STOP_EN(STOP_EN), .TICK_EN(TICK_EN),
        .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .FRAME_ERR(FRAME_ERR),
        .BUSY(BUSY), .STATE_DBG(STATE_DBG)
    );

    // Clock
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   e;
    logic [DW-1:0] last_good = '0;
    logic          par_err_q = 1'b0;
    logic          stop_err_q = 1'b0;
    logic          force_par = 1'b0;

    assign PARITY_ERROR = par_err_q | force_par;
    assign STOP_ERROR   = stop_err_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, want);
        end
    endtask

    // External checker: even parity over data+parity bit, stop bit must be 1.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
        end else if (RX_tick && TICK_EN) begin
            if (ASS_EN)  par_err_q  <= ^{DATA, SER_DATA};
            if (STOP_EN) stop_err_q <= ~SER_DATA;
        end
    end

    // Scoreboard: every pulse must match the oldest queued frame outcome.
    always @(negedge CLK) begin
        if (RST) begin
            if (DATA_VALID && FRAME_ERR) check("both_pulses", 1, 0);
            if (DATA_VALID || FRAME_ERR) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {FRAME_ERR, DATA_VALID}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_is_err", FRAME_ERR, e[DW]);
                    if (!e[DW]) begin
                        last_good = e[DW-1:0];
                        check("p_data", P_DATA, e[DW-1:0]);
                    end else begin
                        check("p_data_hold", P_DATA, last_good);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        RX_tick = 1'b1;
        @(posedge CLK); #1;
        RX_tick = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
    endtask

    task automatic send_ticks(input logic b, input int n);
        RX_IN = b;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic bad_par,
                              input logic bad_stop, input logic flip_par_en);
        logic pbit;
        pbit = (^d) ^ bad_par;
        exp_q.push_back({bad_stop | (par & bad_par), d});
        PAR_EN = par;
        send_ticks(1'b0, OS);
        if (flip_par_en) PAR_EN = ~par;
        for (int i = 0; i < DW; i++) send_ticks(d[i], OS);
        if (par) begin
            send_ticks(pbit, H);
            check("ass_en", ASS_EN, 1);
            send_ticks(pbit, OS - H);
        end
        if (bad_stop) begin
            send_ticks(1'b0, 4);
            check("stop_en", STOP_EN, 1);
            send_ticks(1'b0, H - 1);
            send_ticks(1'b1, OS - H - 3);
        end else begin
            send_ticks(1'b1, 4);
            check("stop_en", STOP_EN, 1);
            send_ticks(1'b1, OS - 4);
        end
        check("frame_done", exp_q.size(), 0);
    endtask

    // Watchdog
    initial begin
        #3_000_000;
        n_errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Stimulus
    initial begin
        logic [DW-1:0] rd;
        logic          rp;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_ser_data", SER_DATA, 1);
        check("rst_data", DATA, 0);
        check("rst_p_data", P_DATA, 0);
        check("rst_valid", DATA_VALID, 0);
        check("rst_ferr", FRAME_ERR, 0);
        check("rst_en", {ASS_EN, STOP_EN, TICK_EN}, 0);
        RST = 1'b1;
        send_ticks(1'b1, 4);

        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0);
        force_par = 1'b1;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        force_par = 1'b0;

        // Start glitch: four low ticks, then the line recovers.
        send_ticks(1'b0, 4);
        send_ticks(1'b1, H + 4);
        check("glitch_idle", BUSY, 0);
        check("glitch_no_pulse", exp_q.size(), 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back, no idle gap.
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            rd = DW'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            send_frame(rd, rp, rp && ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
            send_ticks(1'b1, $urandom_range(0, 3));
        end
        send_frame(8'hC6, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 4 aborts the frame.
        PAR_EN = 1'b0;
        rd = 8'hAF;
        send_ticks(1'b0, OS);
        for (int i = 0; i < 4; i++) send_ticks(rd[i], OS);
        send_ticks(rd[4], H);
        check("mid_busy", BUSY, 1);
        RST = 1'b0;
        #1;
        last_good = '0;
        check("mrst_busy", BUSY, 0);
        check("mrst_ser_data", SER_DATA, 1);
        check("mrst_data", DATA, 0);
        check("mrst_p_data", P_DATA, 0);
        check("mrst_pulses", {DATA_VALID, FRAME_ERR}, 0);
        check("mrst_en", {ASS_EN, STOP_EN, TICK_EN}, 0);
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        send_ticks(1'b1, OS);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);

        send_ticks(1'b1, 2 * OS);
        check("final_queue", exp_q.size(), 0);
        check("final_idle", BUSY, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
